// File: rtl/alu_op_sequencer_if.sv
// Request/response bus between a requester (CPU control unit or debug port)
// and the ALU operation sequencer. The requester side is the master.
interface alu_op_sequencer_if #(
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [DATA_W-1:0] req_p;
    logic [DATA_W-1:0] req_q;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_low;
    logic [DATA_W-1:0] rsp_high;
    logic [4:0]        rsp_flags;

    modport master (
        output req_valid, req_op, req_p, req_q, rsp_ready,
        input  req_ready, rsp_valid, rsp_low, rsp_high, rsp_flags
    );

    modport slave (
        input  req_valid, req_op, req_p, req_q, rsp_ready,
        output req_ready, rsp_valid, rsp_low, rsp_high, rsp_flags
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts one request, pulses the ALU enable, reads
// BR (C9) and, for multiply, MR (C10), then returns the result on a
// valid/ready response. All strobes are registered decodes of the next state,
// so at most one of enable/C9/C10 is ever high and none of them glitch.
module alu_op_sequencer #(
    parameter int         DATA_W = 16,
    parameter logic [2:0] OP_MPY = 3'b010,
    parameter int         CNT_W  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    alu_op_sequencer_if.slave    req_if,
    output logic [DATA_W-1:0]    o_alu_p,
    output logic [DATA_W-1:0]    o_alu_q,
    output logic [2:0]           o_alu_op,
    output logic                 o_alu_en,
    output logic                 o_c9,
    output logic                 o_c10,
    input  logic [DATA_W-1:0]    i_alu_br,
    input  logic [DATA_W-1:0]    i_alu_mr,
    input  logic [4:0]           i_alu_flags,
    input  logic                 i_flush,
    output logic                 o_busy,
    output logic [CNT_W-1:0]     o_op_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_RD_BR = 3'd2,
        S_RD_MR = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              w_accept;
    logic              w_complete;

    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              r_alu_en;
    logic              r_c9;
    logic              r_c10;
    logic              r_busy;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_p;
    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] r_low;
    logic [DATA_W-1:0] r_high;
    logic [4:0]        r_flags;
    logic [CNT_W-1:0]  r_op_count;

    // Next-state and handshake decode; flush overrides every transition
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        if (i_flush) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_if.req_valid) begin
                        w_next_state = S_EXEC;
                        w_accept     = 1'b1;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
                S_EXEC:  w_next_state = S_RD_BR;
                S_RD_BR: begin
                    if (r_op == OP_MPY) begin
                        w_next_state = S_RD_MR;
                    end else begin
                        w_next_state = S_RESP;
                    end
                end
                S_RD_MR: w_next_state = S_RESP;
                S_RESP: begin
                    if (req_if.rsp_ready) begin
                        w_next_state = S_IDLE;
                        w_complete   = 1'b1;
                    end else begin
                        w_next_state = S_RESP;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Registered strobes and status, decoded from the state being entered
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_alu_en    <= 1'b0;
            r_c9        <= 1'b0;
            r_c10       <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_req_ready <= (w_next_state == S_IDLE);
            r_busy      <= (w_next_state != S_IDLE);
            r_alu_en    <= (w_next_state == S_EXEC);
            r_c9        <= (w_next_state == S_RD_BR);
            r_c10       <= (w_next_state == S_RD_MR);
            r_rsp_valid <= (w_next_state == S_RESP);
        end
    end

    // Operand/opcode latch; values persist through IDLE until the next accept
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op <= 3'b000;
            r_p  <= {DATA_W{1'b0}};
            r_q  <= {DATA_W{1'b0}};
        end else if (w_accept) begin
            r_op <= req_if.req_op;
            r_p  <= req_if.req_p;
            r_q  <= req_if.req_q;
        end else begin
            r_op <= r_op;
            r_p  <= r_p;
            r_q  <= r_q;
        end
    end

    // Result capture: BR and flags while C9 is high, MR while C10 is high
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_low   <= {DATA_W{1'b0}};
            r_high  <= {DATA_W{1'b0}};
            r_flags <= 5'b00000;
        end else if (!i_flush && (r_state == S_RD_BR)) begin
            r_low   <= i_alu_br;
            r_flags <= i_alu_flags;
            r_high  <= {DATA_W{1'b0}};
        end else if (!i_flush && (r_state == S_RD_MR)) begin
            r_high  <= i_alu_mr;
        end else begin
            r_low   <= r_low;
            r_high  <= r_high;
            r_flags <= r_flags;
        end
    end

    // Completed-response counter; wraps naturally at its width
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op_count <= {CNT_W{1'b0}};
        end else if (w_complete) begin
            r_op_count <= r_op_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_op_count <= r_op_count;
        end
    end

    assign req_if.req_ready = r_req_ready;
    assign req_if.rsp_valid = r_rsp_valid;
    assign req_if.rsp_low   = r_low;
    assign req_if.rsp_high  = r_high;
    assign req_if.rsp_flags = r_flags;
    assign o_alu_p          = r_p;
    assign o_alu_q          = r_q;
    assign o_alu_op         = r_op;
    assign o_alu_en         = r_alu_en;
    assign o_c9             = r_c9;
    assign o_c10            = r_c10;
    assign o_busy           = r_busy;
    assign o_op_count       = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed plan items followed by
// random operations, with a stand-in ALU and a behavioural result model.
module tb_alu_op_sequencer;
    localparam int         DATA_W = 16;
    localparam int         CNT_W  = 2;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MPY = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic [DATA_W-1:0] alu_p, alu_q, alu_br, alu_mr;
    logic [2:0]        alu_op;
    logic              alu_en, c9, c10, busy;
    logic [4:0]        alu_flags;
    logic [CNT_W-1:0]  op_count;
    logic [DATA_W-1:0] fa_br = 16'h0000;
    logic [DATA_W-1:0] fa_mr = 16'h0000;
    logic [4:0]        fa_flags = 5'b00000;
    logic [DATA_W-1:0] obs_low, obs_high;
    logic [4:0]        obs_flags;
    int                checks = 0;
    int                errors = 0;
    int                exp_count = 0;
    int                wrap_seq [5] = '{1, 2, 3, 0, 1};

    alu_op_sequencer_if #(.DATA_W(DATA_W)) u_if ();

    alu_op_sequencer #(.DATA_W(DATA_W), .OP_MPY(OP_MPY), .CNT_W(CNT_W)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .req_if(u_if),
        .o_alu_p(alu_p), .o_alu_q(alu_q), .o_alu_op(alu_op), .o_alu_en(alu_en),
        .o_c9(c9), .o_c10(c10), .i_alu_br(alu_br), .i_alu_mr(alu_mr),
        .i_alu_flags(alu_flags), .i_flush(flush), .o_busy(busy), .o_op_count(op_count)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {ZF,CF,OF,NF,MF, high, low}
    function automatic logic [36:0] alu_ref(input logic [2:0] op, input logic [15:0] p, input logic [15:0] q);
        logic [16:0] s;
        logic [31:0] prod;
        logic [15:0] lo, hi;
        logic        zf, cf, of_f, nf, mf;
        lo = 16'h0000; hi = 16'h0000; cf = 1'b0; of_f = 1'b0; mf = 1'b0;
        s = 17'h00000; prod = 32'h0;
        case (op)
            3'b000: begin s = {1'b0, p} + {1'b0, q}; lo = s[15:0]; cf = s[16];
                          of_f = (p[15] == q[15]) && (lo[15] != p[15]); end
            3'b001: begin s = {1'b0, p} - {1'b0, q}; lo = s[15:0]; cf = s[16];
                          of_f = (p[15] != q[15]) && (lo[15] != p[15]); end
            3'b010: begin prod = {16'h0000, p} * {16'h0000, q}; lo = prod[15:0];
                          hi = prod[31:16]; mf = (hi != 16'h0000); end
            3'b011: lo = p & q;
            3'b100: lo = p | q;
            3'b101: lo = p ^ q;
            3'b110: lo = p >> q[3:0];
            default: lo = p << q[3:0];
        endcase
        zf = ({hi, lo} == 32'h0);
        nf = (op == 3'b010) ? hi[15] : lo[15];
        return {zf, cf, of_f, nf, mf, hi, lo};
    endfunction

    // Stand-in ALU: result registers update on the enable pulse
    always @(posedge clk) begin
        if (alu_en) {fa_flags, fa_mr, fa_br} <= alu_ref(alu_op, alu_p, alu_q);
    end
    assign alu_br    = c9  ? fa_br : 16'h0000;
    assign alu_mr    = c10 ? fa_mr : 16'h0000;
    assign alu_flags = fa_flags;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        chk("strobe_onehot0", 64'($onehot0({alu_en, c9, c10})), 64'd1);
    endtask

    task automatic chk_ops(input logic [2:0] op, input logic [15:0] p, input logic [15:0] q);
        chk("alu_op_hold", 64'(alu_op), 64'(op));
        chk("alu_p_hold", 64'(alu_p), 64'(p));
        chk("alu_q_hold", 64'(alu_q), 64'(q));
    endtask

    task automatic do_op(input logic [2:0] op, input logic [15:0] p, input logic [15:0] q,
                         input int hold, input bit keep_valid);
        logic [36:0] r;
        r = alu_ref(op, p, q);
        u_if.req_valid = 1'b1; u_if.req_op = op; u_if.req_p = p; u_if.req_q = q;
        u_if.rsp_ready = 1'b0;
        chk("req_ready_idle", 64'(u_if.req_ready), 64'd1);
        step();
        if (!keep_valid) begin
            u_if.req_valid = 1'b0; u_if.req_op = 3'($urandom);
            u_if.req_p = 16'($urandom); u_if.req_q = 16'($urandom);
        end
        chk("exec_alu_en", 64'(alu_en), 64'd1);
        chk("exec_c9", 64'(c9), 64'd0);
        chk("exec_busy", 64'(busy), 64'd1);
        chk("exec_req_ready", 64'(u_if.req_ready), 64'd0);
        chk_ops(op, p, q);
        step();
        chk("rdbr_c9", 64'(c9), 64'd1);
        chk("rdbr_c10", 64'(c10), 64'd0);
        chk("rdbr_rsp_valid", 64'(u_if.rsp_valid), 64'd0);
        if (op == OP_MPY) begin
            step();
            chk("rdmr_c10", 64'(c10), 64'd1);
            chk("rdmr_rsp_valid", 64'(u_if.rsp_valid), 64'd0);
        end
        step();
        chk("resp_valid", 64'(u_if.rsp_valid), 64'd1);
        chk("resp_low", 64'(u_if.rsp_low), 64'(r[15:0]));
        chk("resp_high", 64'(u_if.rsp_high), 64'(r[31:16]));
        chk("resp_flags", 64'(u_if.rsp_flags), 64'(r[36:32]));
        chk("resp_count", 64'(op_count), 64'(exp_count));
        chk_ops(op, p, q);
        obs_low = u_if.rsp_low; obs_high = u_if.rsp_high; obs_flags = u_if.rsp_flags;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", 64'(u_if.rsp_valid), 64'd1);
            chk("hold_low", 64'(u_if.rsp_low), 64'(r[15:0]));
            chk("hold_req_ready", 64'(u_if.req_ready), 64'd0);
        end
        u_if.rsp_ready = 1'b1;
        step();
        u_if.rsp_ready = 1'b0;
        exp_count = (exp_count + 1) % (1 << CNT_W);
        chk("done_valid", 64'(u_if.rsp_valid), 64'd0);
        chk("done_count", 64'(op_count), 64'(exp_count));
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_req_ready", 64'(u_if.req_ready), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        u_if.req_valid = 1'b0; u_if.req_op = 3'b000; u_if.req_p = 16'h0000;
        u_if.req_q = 16'h0000; u_if.rsp_ready = 1'b0;
        #23;
        chk("rst_req_ready", 64'(u_if.req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(u_if.rsp_valid), 64'd0);
        chk("rst_strobes", 64'({alu_en, c9, c10}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_count", 64'(op_count), 64'd0);
        chk("rst_result", 64'({u_if.rsp_low, u_if.rsp_high, u_if.rsp_flags}), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        step();

        // Directed plan items
        do_op(OP_ADD, 16'd5, 16'd7, 0, 1'b0);
        chk("add_low", 64'(obs_low), 64'h000C);
        chk("add_high", 64'(obs_high), 64'h0000);
        chk("add_count", 64'(op_count), 64'd1);
        do_op(OP_MPY, 16'h0100, 16'h0100, 0, 1'b0);
        chk("mpy_low", 64'(obs_low), 64'h0000);
        chk("mpy_high", 64'(obs_high), 64'h0001);
        chk("mpy_zf", 64'(obs_flags[4]), 64'd0);
        do_op(OP_SUB, 16'd5, 16'd5, 0, 1'b0);
        chk("sub_low", 64'(obs_low), 64'h0000);
        chk("sub_zf", 64'(obs_flags[4]), 64'd1);
        chk("sub_of", 64'(obs_flags[2]), 64'd0);
        do_op(OP_AND, 16'h0F0F, 16'h00FF, 10, 1'b1);
        chk("and_low", 64'(obs_low), 64'h000F);
        do_op(OP_AND, 16'h0F0F, 16'h00FF, 0, 1'b0);

        // Flush during RD_BR of a multiply
        u_if.req_valid = 1'b1; u_if.req_op = OP_MPY; u_if.req_p = 16'h0100; u_if.req_q = 16'h0100;
        step(); u_if.req_valid = 1'b0;
        step();
        chk("flush_pre_c9", 64'(c9), 64'd1);
        flush = 1'b1; step(); flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_req_ready", 64'(u_if.req_ready), 64'd1);
        chk("flush_c10", 64'(c10), 64'd0);
        chk("flush_count", 64'(op_count), 64'(exp_count));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_no_rsp", 64'({u_if.rsp_valid, c10}), 64'd0);
        end
        // Flush beats a simultaneous accept
        u_if.req_valid = 1'b1; u_if.req_op = OP_ADD; flush = 1'b1;
        step(); u_if.req_valid = 1'b0; flush = 1'b0;
        chk("flush_vs_accept", 64'({alu_en, busy}), 64'd0);
        // Flush beats a simultaneous response handshake
        u_if.req_valid = 1'b1; u_if.req_op = OP_ADD; u_if.req_p = 16'd1; u_if.req_q = 16'd2;
        step(); u_if.req_valid = 1'b0;
        step(); step();
        chk("flush_hs_valid_pre", 64'(u_if.rsp_valid), 64'd1);
        u_if.rsp_ready = 1'b1; flush = 1'b1;
        step(); u_if.rsp_ready = 1'b0; flush = 1'b0;
        chk("flush_vs_hs_count", 64'(op_count), 64'(exp_count));
        chk("flush_vs_hs_valid", 64'(u_if.rsp_valid), 64'd0);

        // Asynchronous reset in the middle of EXEC
        u_if.req_valid = 1'b1; u_if.req_op = OP_SUB; u_if.req_p = 16'h1234; u_if.req_q = 16'h0034;
        step(); u_if.req_valid = 1'b0;
        chk("mid_exec_en", 64'(alu_en), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_strobes", 64'({alu_en, c9, c10, u_if.rsp_valid, busy}), 64'd0);
        chk("arst_req_ready", 64'(u_if.req_ready), 64'd1);
        chk("arst_count", 64'(op_count), 64'd0);
        chk("arst_operands", 64'({alu_op, alu_p, alu_q}), 64'd0);
        chk("arst_result", 64'({u_if.rsp_low, u_if.rsp_high, u_if.rsp_flags}), 64'd0);
        exp_count = 0;
        @(negedge clk); rst_n = 1'b1;
        step();

        // Counter wrap: five back-to-back adds
        for (int i = 0; i < 5; i++) begin
            do_op(OP_ADD, 16'($urandom), 16'($urandom), 0, 1'b0);
            chk("wrap_seq", 64'(op_count), 64'(wrap_seq[i]));
        end

        // Random operations with random backpressure
        for (int i = 0; i < 30; i++) begin
            do_op(3'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
